// File: rtl/hilbert_frame_sequencer.sv
// rtl/hilbert_frame_sequencer.sv - frame-level sequencer feeding a Hilbert FIR and tagging its outputs
//
// Purpose:
//   Accepts one frame of samples over in_valid/in_ready and feeds the FIR one
//   sample per clock. The FIR has no clock enable, so the FIR is held in reset
//   between frames, zeros are inserted on input gaps, and the FIR is flushed
//   for FIR_LATENCY cycles after the frame. A valid/last shift register matched
//   to the FIR latency tags fir_re/fir_im toward the downstream demodulator.
//
// Ports:
//   clock, reset_n        rising-edge clock, asynchronous active-low reset
//   start, frame_len      frame start pulse (IDLE only) and frame length
//   abort                 synchronous abort, honoured in any non-IDLE state
//   in_data, in_valid     input sample stream; in_ready high in STREAM only
//   fir_in, fir_reset     FIR sample input and synchronous active-high reset
//   fir_re, fir_im        FIR outputs, passed to out_re/out_im combinationally
//   out_valid, out_last   tags for out_re/out_im
//   busy, done, underrun  status: not idle, end-of-frame pulse, sticky gap flag
//   gap_count             only with HILBERT_SEQ_STATS_EN: saturating STREAM gap count
//
// Configuration macro: HILBERT_SEQ_STATS_EN

module hilbert_frame_sequencer #(
  parameter int TOTAL_BITS  = 12,
  parameter int LEN_BITS    = 16,
  parameter int FIR_LATENCY = 9
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [LEN_BITS-1:0]   frame_len,
  input  logic                  abort,
  input  logic [TOTAL_BITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [TOTAL_BITS-1:0] fir_in,
  output logic                  fir_reset,
  input  logic [TOTAL_BITS-1:0] fir_re,
  input  logic [TOTAL_BITS-1:0] fir_im,
  output logic [TOTAL_BITS-1:0] out_re,
  output logic [TOTAL_BITS-1:0] out_im,
  output logic                  out_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  underrun
`ifdef HILBERT_SEQ_STATS_EN
  ,
  output logic [LEN_BITS-1:0]   gap_count
`endif
);

  // Wide enough to hold FIR_LATENCY-1 even when FIR_LATENCY is 1.
  localparam int DRAIN_BITS = $clog2(FIR_LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLEAR  = 2'd1,
    S_STREAM = 2'd2,
    S_DRAIN  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [LEN_BITS-1:0]     len_q, len_d;
  logic [LEN_BITS-1:0]     count_q, count_d;
  logic [DRAIN_BITS-1:0]   drain_q, drain_d;
  logic [TOTAL_BITS-1:0]   fir_in_q, fir_in_d;
  logic [FIR_LATENCY-1:0]  vpipe_q, vpipe_d;
  logic [FIR_LATENCY-1:0]  lpipe_q, lpipe_d;
  logic                    underrun_q, underrun_d;
  logic                    done_q, done_d;

  logic push_v;
  logic push_l;
  logic flush;
  logic is_last;
  logic aborting;

  // Only meaningful in STREAM, where len_q is known to be non-zero.
  assign is_last  = (count_q == (len_q - LEN_BITS'(1)));
  assign aborting = abort && (state_q != S_IDLE);

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    count_d    = count_q;
    drain_d    = '0;
    fir_in_d   = '0;
    underrun_d = underrun_q;
    done_d     = 1'b0;
    push_v     = 1'b0;
    push_l     = 1'b0;
    flush      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d      = frame_len;
          count_d    = '0;
          underrun_d = 1'b0;
          state_d    = S_CLEAR;
        end
      end
      S_CLEAR: begin
        flush   = 1'b1;
        state_d = (len_q == '0) ? S_DRAIN : S_STREAM;
      end
      S_STREAM: begin
        if (in_valid) begin
          fir_in_d = in_data;
          push_v   = 1'b1;
          push_l   = is_last;
          count_d  = count_q + LEN_BITS'(1);
          if (is_last) begin
            state_d = S_DRAIN;
          end
        end else begin
          // Zero keeps the free-running FIR's history consistent with a gap.
          underrun_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_BITS'(FIR_LATENCY - 1)) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRAIN_BITS'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort overrides everything above; the pipeline is emptied on the same edge
    // so no stale tags reach the demodulator.
    if (aborting) begin
      state_d  = S_IDLE;
      fir_in_d = '0;
      done_d   = 1'b0;
      flush    = 1'b1;
    end

    if (flush) begin
      vpipe_d = '0;
      lpipe_d = '0;
    end else begin
      vpipe_d[0] = push_v;
      lpipe_d[0] = push_l;
      for (int i = 1; i < FIR_LATENCY; i++) begin
        vpipe_d[i] = vpipe_q[i-1];
        lpipe_d[i] = lpipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      count_q    <= '0;
      drain_q    <= '0;
      fir_in_q   <= '0;
      vpipe_q    <= '0;
      lpipe_q    <= '0;
      underrun_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      drain_q    <= drain_d;
      fir_in_q   <= fir_in_d;
      vpipe_q    <= vpipe_d;
      lpipe_q    <= lpipe_d;
      underrun_q <= underrun_d;
      done_q     <= done_d;
    end
  end

`ifdef HILBERT_SEQ_STATS_EN
  logic [LEN_BITS-1:0] gap_q, gap_d;

  always_comb begin
    gap_d = gap_q;
    if ((state_q == S_IDLE) && start) begin
      gap_d = '0;
    end else if ((state_q == S_STREAM) && !in_valid && (gap_q != '1)) begin
      gap_d = gap_q + LEN_BITS'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_d;
    end
  end

  assign gap_count = gap_q;
`endif

  // The FIR is only released while samples or flush zeros are flowing.
  assign fir_reset = (state_q == S_IDLE) || (state_q == S_CLEAR);
  assign fir_in    = fir_in_q;
  assign in_ready  = (state_q == S_STREAM);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign underrun  = underrun_q;
  assign out_re    = fir_re;
  assign out_im    = fir_im;
  assign out_valid = vpipe_q[FIR_LATENCY-1];
  assign out_last  = lpipe_q[FIR_LATENCY-1];

endmodule

// File: tb/tb_hilbert_frame_sequencer.sv
// tb/tb_hilbert_frame_sequencer.sv - scoreboard bench for hilbert_frame_sequencer
module tb_hilbert_frame_sequencer;
  localparam int TB = 12;
  localparam int LB = 16;
  localparam int L  = 9;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          in_valid = 1'b0;
  logic [LB-1:0] frame_len = '0;
  logic [TB-1:0] in_data = '0;
  logic [TB-1:0] fir_re, fir_im, fir_in, out_re, out_im;
  logic          in_ready, fir_reset, out_valid, out_last, busy, done, underrun;
`ifdef HILBERT_SEQ_STATS_EN
  logic [LB-1:0] gap_count;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [TB-1:0] data;
    bit            last;
    int            t;
  } exp_t;

  exp_t exp_q[$];
  int   done_exp_q[$];

  // Stand-in FIR: a pure delay so that the tagged output equals the accepted sample.
  logic [TB-1:0] fd [L-1];

  hilbert_frame_sequencer #(.TOTAL_BITS(TB), .LEN_BITS(LB), .FIR_LATENCY(L)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .frame_len(frame_len),
    .abort(abort), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .fir_in(fir_in), .fir_reset(fir_reset), .fir_re(fir_re), .fir_im(fir_im),
    .out_re(out_re), .out_im(out_im), .out_valid(out_valid), .out_last(out_last),
    .busy(busy), .done(done), .underrun(underrun)
`ifdef HILBERT_SEQ_STATS_EN
    , .gap_count(gap_count)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    fd[0] <= fir_in;
    for (int i = 1; i < L - 1; i++) fd[i] <= fd[i-1];
  end
  assign fir_re = fd[L-2];
  assign fir_im = ~fd[L-2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a tagged output or done.
  always @(negedge clock) begin
    exp_t          e;
    logic [TB-1:0] im_e;
    int            dt;
    if (reset_n) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out_valid at cycle %0d", cyc);
        end else begin
          e    = exp_q.pop_front();
          im_e = ~e.data;
          chk("out_time", cyc, e.t);
          chk("out_re", {20'd0, out_re}, {20'd0, e.data});
          chk("out_im", {20'd0, out_im}, {20'd0, im_e});
          chk("out_last", {31'd0, out_last}, {31'd0, e.last});
        end
      end
      if (done) begin
        if (done_exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done at cycle %0d", cyc);
        end else begin
          dt = done_exp_q.pop_front();
          chk("done_time", cyc, dt);
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One frame from an IDLE cycle. pat/patn force the first valid decisions;
  // abort_at aborts on that accept; poke pulses start during DRAIN.
  task automatic run_frame(input int len, input int gap_pct, input logic [7:0] pat,
                           input int patn, input int abort_at, input bit poke,
                           input bit abort_with_start);
    int acc = 0, idx = 0, gaps = 0, s, done_t, a;
    bit exp_ur = 0, v, aborted = 0;
    logic [TB-1:0] d;
    s = cyc;
    start = 1'b1; frame_len = LB'(len); abort = abort_with_start;
    step();
    start = 1'b0; abort = 1'b0;
    chk("clear_busy", {31'd0, busy}, 32'd1);
    chk("clear_underrun", {31'd0, underrun}, 32'd0);
    chk("clear_fir_reset", {31'd0, fir_reset}, 32'd1);
    chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
    if (len == 0) begin
      done_t = s + L + 2;
      step();
      chk("len0_in_ready", {31'd0, in_ready}, 32'd0);
    end else begin
      step();
      while (acc < len) begin
        chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        chk("stream_fir_reset", {31'd0, fir_reset}, 32'd0);
        if (idx < patn) v = pat[idx];
        else if (idx > 4 * len + 50) v = 1'b1;
        else v = ($urandom_range(99) >= gap_pct);
        idx++;
        d = TB'($urandom);
        in_valid = v; in_data = d;
        if (v) begin
          acc++;
          exp_q.push_back('{data: d, last: (acc == len), t: cyc + L});
          if (acc == abort_at) begin abort = 1'b1; aborted = 1'b1; end
        end else begin
          exp_ur = 1'b1; gaps++;
        end
        step();
        in_valid = 1'b0; abort = 1'b0;
        chk("fir_in", {20'd0, fir_in}, (v && !aborted) ? {20'd0, d} : 32'd0);
        if (aborted) break;
      end
      if (aborted) begin
        a = cyc - 1;
        while (exp_q.size() > 0 && exp_q[$].t > a) void'(exp_q.pop_back());
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (L + 3) step();
        chk("abort_underrun_held", {31'd0, underrun}, {31'd0, exp_ur});
        return;
      end
      done_t = cyc + L;
      chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
      chk("drain_busy", {31'd0, busy}, 32'd1);
    end
    done_exp_q.push_back(done_t);
    if (poke) begin
      start = 1'b1; frame_len = LB'(5);
      step();
      start = 1'b0;
    end
    while (cyc < done_t + 1) step();
    chk("end_busy", {31'd0, busy}, 32'd0);
    chk("end_underrun", {31'd0, underrun}, {31'd0, exp_ur});
`ifdef HILBERT_SEQ_STATS_EN
    chk("gap_count", {16'd0, gap_count}, 32'(gaps));
`endif
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_fir_reset", {31'd0, fir_reset}, 32'd1);
    chk("rst_fir_in", {20'd0, fir_in}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    reset_n = 1'b1;
    step();

    run_frame(4, 0, 8'h0F, 4, 0, 0, 0);          // steady frame of 4
    run_frame(3, 0, 8'b0000_1101, 4, 0, 0, 0);   // valid 1,0,1,1
    run_frame(0, 0, 8'h00, 0, 0, 0, 0);          // empty frame
    run_frame(8, 0, 8'hFF, 8, 2, 0, 0);          // abort on 2nd accept
    run_frame(5, 20, 8'h00, 0, 0, 0, 0);         // clean frame after abort
    run_frame(6, 10, 8'h00, 0, 0, 1, 0);         // start poked during DRAIN
    run_frame(3, 0, 8'h00, 0, 0, 0, 1);          // start and abort together in IDLE
    for (int f = 0; f < 6; f++)
      run_frame($urandom_range(20, 1), $urandom_range(50), 8'h00, 0, 0, 0, 0);

    // Asynchronous reset in the middle of a frame with an underrun pending.
    start = 1'b1; frame_len = LB'(6);
    step();
    start = 1'b0;
    step();
    in_valid = 1'b1; in_data = TB'(12'h111); step();
    in_valid = 1'b0; step();
    in_valid = 1'b1; in_data = TB'(12'h222); step();
    in_valid = 1'b0;
    chk("pre_reset_underrun", {31'd0, underrun}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_fir_reset", {31'd0, fir_reset}, 32'd1);
    chk("midrst_fir_in", {20'd0, fir_in}, 32'd0);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_underrun", {31'd0, underrun}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    step();
    reset_n = 1'b1;
    repeat (L + 3) step();
    run_frame(4, 0, 8'h00, 0, 0, 0, 0);

    chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("done_queue_empty", 32'(done_exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
